keypad_num_entry: RTL
=====================

// Module: keypad_num_entry
// PURPOSE
//   Scans a 4x4 matrix keypad, debounces it and builds a signed decimal number from key presses.
//   Number format is sign-magnitude: bit7 = sign, bits6:0 = magnitude 0..127.
//   The same 8-bit format feeds the four-digit seven-segment display driver (edit_value for live echo)
//   and the CPU input path (value/valid).
// PARAMETERS
//   SCAN_DIV        100000  clk cycles each keypad row is driven (row period)
//   DEBOUNCE_SCANS  4       consecutive identical full-frame samples needed to accept a key state
// PORTS
//   clk         in   1  system clock; all state on posedge clk
//   rst         in   1  asynchronous, active-high reset
//   col_n       in   4  keypad columns, active-low (pulled up), asynchronous to clk
//   row_n       out  4  keypad row drive, active-low, exactly one row low at any time
//   edit_value  out  8  number being edited, {sign, mag[6:0]}
//   value       out  8  last committed number, held until next commit
//   valid       out  1  one-cycle pulse when value is updated
//   err         out  1  one-cycle pulse when a digit is rejected
// BEHAVIOUR
//   Reset (async): row_n=4'b1110, edit_value=0, value=0, valid=0, err=0, digit count=0, key FSM=RELEASED.
//   Scan:
//   - Row index r cycles 0..3 and advances every SCAN_DIV cycles, wrapping 3->0; row_n=~(1<<r).
//   - col_n is passed through a 2-flop synchronizer.
//   - On the last cycle of each row period, the synchronized ~col_n is stored into bits [4r+3:4r] of a 16-bit frame snapshot.
//   Frame decode (at end of row 3):
//   - Exactly one bit set -> candidate = key code.
//   - Zero bits or two or more bits set -> candidate = NONE. Multi-key presses are never reported.
//   - Key map, row r / col c:
//     r0: 1 2 3 A
//     r1: 4 5 6 B
//     r2: 7 8 9 C
//     r3: * 0 # D
//   Debounce:
//   - Counter resets to 1 whenever the candidate differs from the previous frame's candidate.
//   - Otherwise the counter increments, saturating at DEBOUNCE_SCANS.
//   - Candidate is stable when the count reaches DEBOUNCE_SCANS.
//   Key FSM:
//   - RELEASED -> PRESSED when a stable key is seen; emit one press event with that code.
//   - PRESSED -> RELEASED when stable NONE is seen.
//   - A stable change key->other key without an intervening stable NONE emits no event. No auto-repeat.
//   Entry actions (registered the cycle after the event):
//   - Digit d:
//     - If count==3 or mag*10+d>127: reject, err=1 for one cycle, edit state unchanged.
//     - Otherwise mag<=mag*10+d, count+1.
//     - Use 11-bit intermediate arithmetic, no truncation before the compare.
//   - A: toggle sign.
//   - B: backspace. mag<=mag/10, count-1; no-op at count 0 (sign kept).
//   - C: clear. mag=0, sign=0, count=0.
//   - D: commit. value<={sign & (mag!=0), mag}; valid=1 for one cycle; then edit state clears as for C.
//     Committing with count 0 yields value=0.
//   - * and #: ignored, no err.
//   Latency: valid/err assert exactly 2 clk cycles after the frame-end sample cycle on which debounce completes.
//   Reset mid-operation clears all state immediately. A key held through reset deassertion is reported once,
//   after DEBOUNCE_SCANS full frames.
//   edit_value={sign,mag} is continuously registered. A negative zero (0x80) may appear in edit_value but
//   never in value.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 cycles)
//   1. Press/release 1,2,7,D -> value=8'h7F, valid high exactly one cycle; edit_value=8'h00 afterwards.
//   2. Press 1,2,8 -> 8 rejected (128>127), err pulse; edit_value=8'h0C. Then D -> value=8'h0C.
//   3. Press 4,2,A,D -> value=8'hAA. Separately, press A,D with no digits -> value=8'h00.
//   4. Bounce: key 5 toggles every 8 cycles for 48 cycles, then held -> exactly one digit accepted; edit_value=8'h05.
//   5. Keys 1 and 2 held together -> no event. B at count 0 -> no change. Then 9,C -> edit_value=8'h00.
//   6. Assert rst mid-entry with 3 held -> all outputs 0 immediately, row_n=4'b1110;
//      after release of rst, edit_value=8'h03 once debounce completes.

Source files
------------

// File: rtl/keypad_num_entry_if.sv
// Keypad matrix plus number-entry result signals for keypad_num_entry.
// The master side is the scanner/entry block; the slave side is the keypad and its consumers.
interface keypad_num_entry_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [7:0] edit_value;
    logic [7:0] value;
    logic       valid;
    logic       err;

    modport master (
        input  col_n,
        output row_n,
        output edit_value,
        output value,
        output valid,
        output err
    );

    modport slave (
        output col_n,
        input  row_n,
        input  edit_value,
        input  value,
        input  valid,
        input  err
    );
endinterface

// File: rtl/keypad_num_entry.sv
// 4x4 keypad scanner with frame debounce and sign-magnitude decimal entry (0..127).
// Key codes are 4*row+col; digits 0..9, A=sign, B=backspace, C=clear, D=commit.
module keypad_num_entry #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    keypad_num_entry_if.master  kp
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DbW  = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {StReleased, StPressed} key_state_e;

    logic [DivW-1:0] div_q;
    logic [1:0]      row_q;
    logic [3:0]      col_s1_q, col_s2_q;
    logic [15:0]     frame_q, frame_now;
    logic            row_end, frame_end;

    assign row_end   = (div_q == DivW'(SCAN_DIV - 1));
    assign frame_end = row_end && (row_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            row_q    <= 2'd0;
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            frame_q  <= '0;
        end else begin
            col_s1_q <= kp.col_n;
            col_s2_q <= col_s1_q;
            if (row_end) begin
                div_q                         <= '0;
                row_q                         <= row_q + 2'd1;
                frame_q[{row_q, 2'b00} +: 4] <= ~col_s2_q;
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

    // Decode sees the row-3 sample being taken this cycle, not the stale stored copy.
    always_comb begin
        frame_now        = frame_q;
        frame_now[15:12] = ~col_s2_q;
    end

    logic       cand_hit;
    logic [3:0] cand_code;
    logic [4:0] cand;

    always_comb begin
        cand_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_now[i]) cand_code = 4'(i);
        end
        cand_hit = (frame_now != 16'd0) && ((frame_now & (frame_now - 16'd1)) == 16'd0);
        cand     = cand_hit ? {1'b1, cand_code} : 5'd0;
    end

    logic [4:0]     prev_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           stable;
    key_state_e     state_q, state_d;
    logic           ev_d, ev_q;
    logic [3:0]     ev_code_q;

    always_comb begin
        db_cnt_d = db_cnt_q;
        if (frame_end) begin
            if (cand != prev_q) begin
                db_cnt_d = DbW'(1);
            end else if (db_cnt_q < DbW'(DEBOUNCE_SCANS)) begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    assign stable = frame_end && (db_cnt_d == DbW'(DEBOUNCE_SCANS));

    always_comb begin
        state_d = state_q;
        ev_d    = 1'b0;
        case (state_q)
            StReleased: begin
                if (stable && cand[4]) begin
                    state_d = StPressed;
                    ev_d    = 1'b1;
                end
            end
            StPressed: begin
                if (stable && !cand[4]) state_d = StReleased;
            end
            default: state_d = StReleased;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= 5'd0;
            db_cnt_q  <= '0;
            state_q   <= StReleased;
            ev_q      <= 1'b0;
            ev_code_q <= 4'd0;
        end else begin
            if (frame_end) prev_q <= cand;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            ev_q     <= ev_d;
            if (ev_d) ev_code_q <= cand[3:0];
        end
    end

    logic [6:0]  mag_q, mag_d;
    logic        sign_q, sign_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  value_q, value_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic [1:0]  key_row, key_col;
    logic        is_digit;
    logic [3:0]  digit;
    logic [10:0] prod;

    assign key_row  = ev_code_q[3:2];
    assign key_col  = ev_code_q[1:0];
    assign is_digit = ((key_col != 2'd3) && (key_row != 2'd3)) || (ev_code_q == 4'd13);
    assign digit    = (ev_code_q == 4'd13) ? 4'd0
                    : ({2'b00, key_row} * 4'd3 + {2'b00, key_col} + 4'd1);
    assign prod     = 11'(mag_q) * 11'd10 + 11'(digit);

    always_comb begin
        mag_d   = mag_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (ev_q) begin
            if (is_digit) begin
                if ((cnt_q == 2'd3) || (prod > 11'd127)) begin
                    err_d = 1'b1;
                end else begin
                    mag_d = 7'(prod);
                    cnt_d = cnt_q + 2'd1;
                end
            end else begin
                case (ev_code_q)
                    4'd3: sign_d = ~sign_q;
                    4'd7: begin
                        if (cnt_q != 2'd0) begin
                            mag_d = mag_q / 7'd10;
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                    4'd11: begin
                        mag_d  = 7'd0;
                        sign_d = 1'b0;
                        cnt_d  = 2'd0;
                    end
                    4'd15: begin
                        // Sign is dropped on zero so a committed value is never 0x80.
                        value_d = {sign_q & (mag_q != 7'd0), mag_q};
                        valid_d = 1'b1;
                        mag_d   = 7'd0;
                        sign_d  = 1'b0;
                        cnt_d   = 2'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q   <= 7'd0;
            sign_q  <= 1'b0;
            cnt_q   <= 2'd0;
            value_q <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign kp.row_n      = ~(4'b0001 << row_q);
    assign kp.edit_value = {sign_q, mag_q};
    assign kp.value      = value_q;
    assign kp.valid      = valid_q;
    assign kp.err        = err_q;

endmodule
